// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the lab CPU control unit.
//   Opcodes, pc_ctrl and alu_op encodings, FSM state type and the
//   EXEC control vector type produced by ins_decode.
package cpu_pkg;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_JMP  = 5'b00100;
  localparam logic [4:0] OP_BZ   = 5'b00101;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic       en_pc;
    logic [1:0] pc_ctrl;
    logic       reg_we;
    logic [1:0] alu_op;
    logic       alu_src;
  } ctrl_t;

endpackage

// File: rtl/cpu_ctrl_ins_decode.sv
// ins_decode: combinational instruction decoder.
//   ir      : latched instruction word
//   zero    : ALU zero flag (used by BZ only)
//   in_exec : high while the FSM is in EXEC; all controls are 0 otherwise
//   ctrl    : EXEC control vector
//   illegal : unknown opcode seen in EXEC
// Macro CTRL_BZ_EN: when defined, opcode 00101 is a branch-if-zero;
// otherwise it is treated as an illegal opcode.
module ins_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  input  logic        zero,
  input  logic        in_exec,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [4:0] opcode;
  assign opcode = ir[15:11];

`ifndef CTRL_BZ_EN
  logic unused_zero;
  assign unused_zero = zero;
`endif

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    if (in_exec) begin
      case (opcode)
        OP_NOP: begin
          ctrl.en_pc   = 1'b1;
          ctrl.pc_ctrl = PC_INC;
        end
        OP_LDI: begin
          ctrl.reg_we  = 1'b1;
          ctrl.alu_src = 1'b1;
          ctrl.alu_op  = ALU_PASS;
          ctrl.en_pc   = 1'b1;
          ctrl.pc_ctrl = PC_INC;
        end
        OP_ADD: begin
          ctrl.reg_we  = 1'b1;
          ctrl.alu_op  = ALU_ADD;
          ctrl.en_pc   = 1'b1;
          ctrl.pc_ctrl = PC_INC;
        end
        OP_SUB: begin
          ctrl.reg_we  = 1'b1;
          ctrl.alu_op  = ALU_SUB;
          ctrl.en_pc   = 1'b1;
          ctrl.pc_ctrl = PC_INC;
        end
        OP_JMP: begin
          ctrl.en_pc   = 1'b1;
          ctrl.pc_ctrl = PC_LOAD;
        end
`ifdef CTRL_BZ_EN
        OP_BZ: begin
          ctrl.en_pc   = 1'b1;
          ctrl.pc_ctrl = zero ? PC_LOAD : PC_INC;
        end
`endif
        OP_HALT: begin
          ctrl.en_pc   = 1'b0;
          ctrl.pc_ctrl = PC_HOLD;
        end
        default: begin
          ctrl.en_pc   = 1'b1;
          ctrl.pc_ctrl = PC_INC;
          illegal      = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle control unit (IDLE/FETCH/DECODE/EXEC/HALT).
//   clk, rst (async, active-low), start, ins (ROM data), zero (ALU flag)
//   rom_en, en_pc, pc_ctrl, offset_addr : ROM / PC controls
//   reg_we, rd_addr, rs_addr, imm       : register-file controls
//   alu_op, alu_src                     : ALU controls
//   halted, err                         : status
// Macro CTRL_BZ_EN enables the BZ instruction (see ins_decode).
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ins,
  input  logic        zero,
  output logic        rom_en,
  output logic        en_pc,
  output logic [1:0]  pc_ctrl,
  output logic [7:0]  offset_addr,
  output logic        reg_we,
  output logic [2:0]  rd_addr,
  output logic [2:0]  rs_addr,
  output logic [7:0]  imm,
  output logic [1:0]  alu_op,
  output logic        alu_src,
  output logic        halted,
  output logic        err
);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        err_q, err_d;
  logic        rom_en_q, rom_en_d;
  logic        halted_q, halted_d;

  ctrl_t       ctrl;
  logic        illegal;
  logic        in_exec;

  assign in_exec = (state_q == ST_EXEC);

  ins_decode u_decode (
    .ir      (ir_q),
    .zero    (zero),
    .in_exec (in_exec),
    .ctrl    (ctrl),
    .illegal (illegal)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        state_d = ST_EXEC;
        ir_d    = ins;
      end
      ST_EXEC:   state_d = (ir_q[15:11] == OP_HALT) ? ST_HALT : ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
    err_d    = err_q | illegal;
    // rom_en and halted are registered from the next state so they are
    // high for exactly the FETCH / HALT cycles.
    rom_en_d = (state_d == ST_FETCH);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ir_q     <= '0;
      err_q    <= 1'b0;
      rom_en_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      err_q    <= err_d;
      rom_en_q <= rom_en_d;
      halted_q <= halted_d;
    end
  end

  assign rom_en      = rom_en_q;
  assign halted      = halted_q;
  assign err         = err_q;
  assign en_pc       = ctrl.en_pc;
  assign pc_ctrl     = ctrl.pc_ctrl;
  assign reg_we      = ctrl.reg_we;
  assign alu_op      = ctrl.alu_op;
  assign alu_src     = ctrl.alu_src;
  assign offset_addr = ir_q[7:0];
  assign imm         = ir_q[7:0];
  assign rd_addr     = ir_q[10:8];
  assign rs_addr     = ir_q[7:5];

endmodule

// File: tb/tb_cpu_ctrl.sv
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] ins = '0;
  logic        zero = 1'b0;
  logic        rom_en, en_pc, reg_we, alu_src, halted, err;
  logic [1:0]  pc_ctrl, alu_op;
  logic [7:0]  offset_addr, imm;
  logic [2:0]  rd_addr, rs_addr;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // {en_pc, pc_ctrl, reg_we, alu_op, alu_src}
  logic [6:0] ctl;
  assign ctl = {en_pc, pc_ctrl, reg_we, alu_op, alu_src};

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_INC  = 7'b1010000;
  localparam logic [6:0] C_LOAD = 7'b1100000;
  localparam logic [6:0] C_LDI  = 7'b1011001;
  localparam logic [6:0] C_ADD  = 7'b1011010;
  localparam logic [6:0] C_SUB  = 7'b1011100;

  cpu_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ins         (ins),
    .zero        (zero),
    .rom_en      (rom_en),
    .en_pc       (en_pc),
    .pc_ctrl     (pc_ctrl),
    .offset_addr (offset_addr),
    .reg_we      (reg_we),
    .rd_addr     (rd_addr),
    .rs_addr     (rs_addr),
    .imm         (imm),
    .alu_op      (alu_op),
    .alu_src     (alu_src),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after entering FETCH; returns just after entering EXEC.
  task automatic run_instr(input logic [15:0] w, input logic z);
    ins  = w;
    zero = z;
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {25'd0, ctl}, {25'd0, C_NONE});
    check({tag, "_stat"}, {29'd0, rom_en, halted, err}, 32'd0);
    check({tag, "_fields"}, {8'd0, offset_addr, imm, 2'd0, rd_addr, rs_addr}, 32'd0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    check_all_zero("reset");

    @(negedge clk) rst = 1'b1;
    tick();
    tick();
    check("idle_no_start", {31'd0, rom_en}, 32'd0);

    // Segment A: LDI, JMP, ADD, SUB, illegal, NOP, HALT
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fetch_rom_en", {31'd0, rom_en}, 32'd1);
    ins = 16'h0905;
    tick();
    check("decode_rom_en", {31'd0, rom_en}, 32'd0);
    check("decode_ctl", {25'd0, ctl}, {25'd0, C_NONE});
    tick();
    check("ldi_ctl", {25'd0, ctl}, {25'd0, C_LDI});
    check("ldi_rd", {29'd0, rd_addr}, 32'd1);
    check("ldi_imm", {24'd0, imm}, 32'h05);
    tick();
    check("refetch_rom_en", {31'd0, rom_en}, 32'd1);

    run_instr(16'h2042, 1'b0);
    check("jmp_ctl", {25'd0, ctl}, {25'd0, C_LOAD});
    check("jmp_target", {24'd0, offset_addr}, 32'h42);
    tick();

    run_instr(16'h1120, 1'b0);
    check("add_ctl", {25'd0, ctl}, {25'd0, C_ADD});
    check("add_regs", {26'd0, rd_addr, rs_addr}, {26'd0, 3'd1, 3'd1});
    tick();

    run_instr(16'h1A40, 1'b0);
    check("sub_ctl", {25'd0, ctl}, {25'd0, C_SUB});
    check("sub_regs", {26'd0, rd_addr, rs_addr}, {26'd0, 3'd2, 3'd2});
    tick();
    check("err_clean", {31'd0, err}, 32'd0);

    run_instr(16'h3000, 1'b0);
    check("illegal_ctl", {25'd0, ctl}, {25'd0, C_INC});
    tick();
    check("illegal_err", {31'd0, err}, 32'd1);

    run_instr(16'h0000, 1'b0);
    check("nop_ctl", {25'd0, ctl}, {25'd0, C_INC});
    tick();
    check("err_sticky", {31'd0, err}, 32'd1);

    run_instr(16'hF800, 1'b0);
    check("halt_ctl", {25'd0, ctl}, {25'd0, C_NONE});
    check("halt_exec_halted", {31'd0, halted}, 32'd0);
    tick();
    check("halted_rise", {30'd0, halted, rom_en}, 32'b10);
    check("halted_ctl", {25'd0, ctl}, {25'd0, C_NONE});
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("halted_hold", {30'd0, halted, rom_en}, 32'b10);

    // Segment B: reset out of HALT, BZ, reset during DECODE
    #2 rst = 1'b0;
    #1;
    check("halt_reset_stat", {29'd0, rom_en, halted, err}, 32'd0);
    @(negedge clk) rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;

    run_instr(16'h2810, 1'b1);
`ifdef CTRL_BZ_EN
    check("bz_taken_ctl", {25'd0, ctl}, {25'd0, C_LOAD});
`else
    check("bz_taken_ctl", {25'd0, ctl}, {25'd0, C_INC});
`endif
    check("bz_target", {24'd0, offset_addr}, 32'h10);
    tick();

    run_instr(16'h2810, 1'b0);
    check("bz_not_taken_ctl", {25'd0, ctl}, {25'd0, C_INC});
    tick();
`ifdef CTRL_BZ_EN
    check("bz_err", {31'd0, err}, 32'd0);
`else
    check("bz_err", {31'd0, err}, 32'd1);
`endif

    // Now in FETCH: load ADD, reset in the middle of DECODE
    ins = 16'h1120;
    tick();
    #3 rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold_we", {31'd0, reg_we}, 32'd0);
    end
    @(negedge clk) rst = 1'b1;
    tick();
    tick();
    check("post_reset_idle", {25'd0, ctl, rom_en}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle control unit for the lab CPU. It drives the program counter's enable, `pc_ctrl` and `offset_addr` inputs, and fetches from the instruction ROM addressed by `pc_out`. It latches the instruction word and decodes it. It issues register-file and ALU controls in a fixed IDLE/FETCH/DECODE/EXEC sequence.

## Interface
- No parameters. Widths are fixed: 16-bit instruction, 8-bit jump target, 3-bit register address.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: leave IDLE; sampled only in IDLE.
- `ins` in 16: ROM read data; valid the cycle after `rom_en`.
- `zero` in 1: ALU zero flag from the last ALU result.
- `rom_en` out 1: ROM read enable.
- `en_pc` out 1: to the PC `en_in`.
- `pc_ctrl` out 2: 01 = increment, 10 = load `offset_addr`, 00 = hold.
- `offset_addr` out 8: jump target, `ir[7:0]`.
- `reg_we` out 1: register-file write enable.
- `rd_addr` out 3: destination register, `ir[10:8]`.
- `rs_addr` out 3: source register, `ir[7:5]`.
- `imm` out 8: immediate, `ir[7:0]`.
- `alu_op` out 2: 00 = pass imm, 01 = add, 10 = sub.
- `alu_src` out 1: 1 selects `imm`, 0 selects `rs`.
- `halted` out 1: high while in HALT.
- `err` out 1: sticky illegal-opcode flag.

## Operation
- Instruction fields: `ir[15:11]` opcode, `ir[10:8]` rd, `ir[7:0]` imm/target, `ir[7:5]` rs.
- Opcodes:
  - NOP 00000
  - LDI 00001: rd <= imm
  - ADD 00010: rd <= rd + rs
  - SUB 00011: rd <= rd - rs
  - JMP 00100: pc <= target
  - BZ 00101: pc <= target if `zero`, else pc+1
  - HALT 11111
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- Transitions:
  - IDLE -> FETCH when `start`=1; otherwise stay.
  - FETCH -> DECODE, with `rom_en`=1.
  - DECODE -> EXEC; `ir` <= `ins` at the end of DECODE.
  - EXEC -> FETCH, or -> HALT if the opcode is HALT.
  - HALT -> HALT until `rst`.
- EXEC outputs (all outputs are 0 outside EXEC except `rom_en`, `halted` and the ir-derived fields):
  - NOP and illegal opcodes: `en_pc`=1, `pc_ctrl`=01. Illegal opcodes also set `err`.
  - LDI: `reg_we`=1, `alu_src`=1, `alu_op`=00, `en_pc`=1, `pc_ctrl`=01.
  - ADD: `reg_we`=1, `alu_src`=0, `alu_op`=01, `en_pc`=1, `pc_ctrl`=01.
  - SUB: `reg_we`=1, `alu_src`=0, `alu_op`=10, `en_pc`=1, `pc_ctrl`=01.
  - JMP: `en_pc`=1, `pc_ctrl`=10.
  - Taken BZ: `en_pc`=1, `pc_ctrl`=10.
  - HALT: `en_pc`=0, `pc_ctrl`=00; PC holds at the HALT address.
- `offset_addr`, `imm`, `rd_addr` and `rs_addr` are driven from `ir` in every state.
- `err` stays 1 until reset; execution continues after an illegal opcode.

## Timing
- Reset values:
  - state = IDLE, `ir` = 0, `err` = 0.
  - All outputs 0, including `pc_ctrl`=00 and `halted`=0.
- An instruction takes 3 cycles (FETCH, DECODE, EXEC). The PC and register file update on the clock edge that ends EXEC.
- `rom_en` is registered against the current `pc_out`; `ins` must be stable through the DECODE cycle.
- `zero` is sampled combinationally in EXEC.
- `start` pulses outside IDLE are ignored.
- `rst` low in any state returns immediately to IDLE with the outputs above. A write in flight is dropped.
- `halted` rises on the first cycle in HALT.

## Configuration
- `CTRL_BZ_EN` defined: BZ is decoded as specified above.
- `CTRL_BZ_EN` undefined: opcode 00101 is illegal. It sets `err` and behaves as NOP. The `zero` input is unused.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams (`OP_NOP` … `OP_HALT`)
  - `pc_ctrl` encodings (`PC_HOLD`, `PC_INC`, `PC_LOAD`)
  - `alu_op` encodings
  - state encoding
- Sub-module `ins_decode` is purely combinational. It takes `ir`, `zero` and `in_exec` and produces the EXEC control vector plus an `illegal` signal.
- `cpu_ctrl` contains the state register, `ir` and `err`.

## Test plan
- Reset, then `start`=1 for one cycle, then ROM `ins`=0x0905 (LDI r1,5) -> cycles FETCH/DECODE/EXEC. In EXEC: `reg_we`=1, `rd_addr`=1, `imm`=0x05, `alu_src`=1, `en_pc`=1, `pc_ctrl`=01.
- `ins`=0x2042 (JMP 0x42) -> in EXEC: `pc_ctrl`=10, `offset_addr`=0x42, `reg_we`=0.
- `ins`=0x2810 (BZ 0x10): with `zero`=1 -> `pc_ctrl`=10, `offset_addr`=0x10. With `zero`=0 -> `pc_ctrl`=01. With the macro off -> `pc_ctrl`=01 and `err`=1.
- `ins`=0xF800 (HALT) -> `en_pc`=0 in EXEC, `halted`=1 the next cycle and thereafter. Further `start` pulses have no effect.
- `ins`=0x3000 (illegal 00110) -> `err`=1 and stays high across the following instructions; `pc_ctrl`=01.
- Assert `rst`=0 during DECODE of an ADD (0x1120) -> all outputs 0 immediately, `reg_we` never asserted, and IDLE is entered.
